seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_pkg.sv | 35 +++
 rtl/seg_hex_decode.sv | 11 +
 rtl/seg_scan_driver.sv | 163 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared segment encoding for the multiplexed seven-segment scan driver.
// Segment bytes are active-low {dp,a,b,c,d,e,f,g}.
package seg_pkg;

  typedef logic [6:0] seg7_t;

  localparam logic [7:0]  SEG_BLANK  = 8'hFF;
  localparam int unsigned SEG_DP_BIT = 7;

  // Hex nibble to active-low a..g pattern
  function automatic seg7_t hex_to_seg7(input logic [3:0] nib);
    seg7_t r;
    case (nib)
      4'h0:    r = 7'h01;
      4'h1:    r = 7'h4F;
      4'h2:    r = 7'h12;
      4'h3:    r = 7'h06;
      4'h4:    r = 7'h4C;
      4'h5:    r = 7'h24;
      4'h6:    r = 7'h20;
      4'h7:    r = 7'h0F;
      4'h8:    r = 7'h00;
      4'h9:    r = 7'h04;
      4'hA:    r = 7'h08;
      4'hB:    r = 7'h60;
      4'hC:    r = 7'h31;
      4'hD:    r = 7'h42;
      4'hE:    r = 7'h30;
      4'hF:    r = 7'h38;
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to seven-segment decoder (dp handled by the caller).
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg7_o
);

  assign seg7_o = hex_to_seg7(nib_i);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex display driver: staged load, frame-synchronous shadow
// update, anti-ghost blanking and leading-zero suppression.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DIV      = 50000,
  parameter int GHOST    = 0
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   data_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    lz_en,
  output logic [7:0]              seg,
  output logic [N_DIGITS-1:0]     dig_sel,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = $clog2((N_DIGITS < 2) ? 2 : N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] staging_q, staging_d, shadow_q, shadow_d;
  logic [N_DIGITS-1:0]   stage_dp_q, stage_dp_d, shadow_dp_q, shadow_dp_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q;
  logic [7:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   dig_sel_q, dig_sel_d;

  logic                  cnt_last_s;
  logic                  boundary_s;
  logic                  ghost_s;
  logic [IDX_W+1:0]      shamt_s;
  logic [3:0]            nib_s;
  logic                  dp_s;
  logic                  upper_zero_s;
  logic [6:0]            seg7_s;

  assign cnt_last_s   = (cnt_q == CNT_LAST);
  assign boundary_s   = cnt_last_s && (idx_q == IDX_LAST);
  assign shamt_s      = {idx_q, 2'b00};
  assign nib_s        = shadow_q[shamt_s +: 4];
  assign dp_s         = shadow_dp_q[idx_q];
  // All nibbles from the current digit up to the MSD are zero
  assign upper_zero_s = ((shadow_q >> shamt_s) == '0);

  generate
    if (GHOST > 0) begin : g_ghost
      localparam logic [CNT_W-1:0] GHOST_C = CNT_W'(GHOST);
      assign ghost_s = (cnt_q < GHOST_C);
    end else begin : g_no_ghost
      assign ghost_s = 1'b0;
    end
  endgenerate

  seg_hex_decode u_dec (
    .nib_i  (nib_s),
    .seg7_o (seg7_s)
  );

  // Dwell counter and digit index advance
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (cnt_last_s) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Staging/shadow transfer; a load on the boundary bypasses staging
  always_comb begin
    staging_d   = staging_q;
    stage_dp_d  = stage_dp_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    busy_d      = busy_q;
    if (boundary_s) begin
      if (load) begin
        staging_d   = data_in;
        stage_dp_d  = dp_in;
        shadow_d    = data_in;
        shadow_dp_d = dp_in;
        busy_d      = 1'b0;
      end else if (busy_q) begin
        shadow_d    = staging_q;
        shadow_dp_d = stage_dp_q;
        busy_d      = 1'b0;
      end else begin
        busy_d      = 1'b0;
      end
    end else if (load) begin
      staging_d  = data_in;
      stage_dp_d = dp_in;
      busy_d     = 1'b1;
    end else begin
      busy_d = busy_q;
    end
  end

  // Next segment and digit-enable pattern for the current dwell position
  always_comb begin
    seg_d     = SEG_BLANK;
    dig_sel_d = '1;
    if (ghost_s) begin
      seg_d     = SEG_BLANK;
      dig_sel_d = '1;
    end else begin
      dig_sel_d[idx_q] = 1'b0;
      if (lz_en && (idx_q != '0) && upper_zero_s) begin
        seg_d = SEG_BLANK;
      end else begin
        seg_d             = {1'b1, seg7_s};
        seg_d[SEG_DP_BIT] = ~dp_s;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      staging_q    <= '0;
      stage_dp_q   <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_BLANK;
      dig_sel_q    <= '1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      staging_q    <= staging_d;
      stage_dp_q   <= stage_dp_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      busy_q       <= busy_d;
      frame_done_q <= boundary_s;
      seg_q        <= seg_d;
      dig_sel_q    <= dig_sel_d;
    end
  end

  assign seg        = seg_q;
  assign dig_sel    = dig_sel_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: cycle-level reference model plus vector table
// and hand-written load/reset corner sequences; second instance with one digit.
module tb_seg_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int GHOST = 1;
  localparam int FRAME = N * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        lz_en = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  dig_sel;
  logic        busy, frame_done;

  logic        load1 = 1'b0;
  logic [3:0]  data1 = 4'h0;
  logic [0:0]  dp1 = 1'b0;
  logic        lz1 = 1'b1;
  logic [7:0]  seg1;
  logic [0:0]  dig1;
  logic        busy1, fd1;

  seg_scan_driver #(.N_DIGITS(N), .DIV(DIV), .GHOST(GHOST)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
    .lz_en(lz_en), .seg(seg), .dig_sel(dig_sel), .busy(busy), .frame_done(frame_done)
  );

  seg_scan_driver #(.N_DIGITS(1), .DIV(4), .GHOST(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load1), .data_in(data1), .dp_in(dp1),
    .lz_en(lz1), .seg(seg1), .dig_sel(dig1), .busy(busy1), .frame_done(fd1)
  );

  always #5 clk = ~clk;

  logic [7:0] seg_tab [16] = '{8'h81, 8'hCF, 8'h92, 8'h86, 8'hCC, 8'hA4, 8'hA0, 8'h8F,
                               8'h80, 8'h84, 8'h88, 8'hE0, 8'hB1, 8'hC2, 8'hB0, 8'hB8};

  int n_chk = 0;
  int n_fail = 0;

  // reference model state: k = position of the upcoming cycle within a frame
  int          k, k1;
  logic [15:0] m_shadow, m_stage;
  logic [3:0]  m_sdp, m_stdp;
  logic        m_busy;
  logic [7:0]  exp_seg, exp_seg1;
  logic [3:0]  exp_dig;
  logic        exp_dig1, exp_fd, exp_fd1;
  logic [7:0]  got [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] ref_seg(input int d, input logic [15:0] sh,
                                         input logic [3:0] dp, input logic lz);
    logic [15:0] upper;
    logic [7:0]  r;
    upper = sh >> (4 * d);
    if (lz && d > 0 && upper == 16'h0000) return 8'hFF;
    r = seg_tab[upper[3:0]];
    if (dp[d]) r[7] = 1'b0;
    return r;
  endfunction

  task automatic model_update();
    int  c, d;
    bit  bnd;
    if (!rst_n) begin
      k = 0; k1 = 0;
      m_shadow = 16'h0; m_stage = 16'h0; m_sdp = 4'h0; m_stdp = 4'h0; m_busy = 1'b0;
      exp_seg = 8'hFF; exp_dig = 4'hF; exp_fd = 1'b0;
      exp_seg1 = 8'hFF; exp_dig1 = 1'b1; exp_fd1 = 1'b0;
    end else begin
      c = k % DIV;
      d = k / DIV;
      bnd = (k == FRAME - 1);
      if (c < GHOST) begin
        exp_seg = 8'hFF;
        exp_dig = 4'hF;
      end else begin
        exp_dig = 4'hF & ~(4'b0001 << d);
        exp_seg = ref_seg(d, m_shadow, m_sdp, lz_en);
      end
      exp_fd = bnd;
      if (bnd && load) begin
        m_shadow = data_in; m_stage = data_in; m_sdp = dp_in; m_stdp = dp_in; m_busy = 1'b0;
      end else if (bnd && m_busy) begin
        m_shadow = m_stage; m_sdp = m_stdp; m_busy = 1'b0;
      end else if (!bnd && load) begin
        m_stage = data_in; m_stdp = dp_in; m_busy = 1'b1;
      end
      k = (k + 1) % FRAME;
      exp_seg1 = 8'h81;
      exp_dig1 = 1'b0;
      exp_fd1 = (k1 == 3);
      k1 = (k1 + 1) % 4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("seg", seg, exp_seg);
    chk("dig_sel", dig_sel, exp_dig);
    chk("busy", busy, m_busy);
    chk("frame_done", frame_done, exp_fd);
    chk("n1_seg", seg1, exp_seg1);
    chk("n1_dig_sel", dig1, exp_dig1);
    chk("n1_frame_done", fd1, exp_fd1);
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      step();
      seen = frame_done;
    end
    chk("frame_done_wait", frame_done, 1);
  endtask

  task automatic capture();
    logic [3:0] pat;
    for (int j = 0; j < 4; j++) got[j] = 8'h00;
    for (int i = 0; i < FRAME; i++) begin
      step();
      for (int j = 0; j < 4; j++) begin
        pat = 4'b0001 << j;
        pat = ~pat;
        if (dig_sel == pat) got[j] = seg;
      end
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    data_in = d; dp_in = dp; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        lz;
    logic [31:0] segs;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{16'h12AF, 4'b0100, 1'b0, 32'hCF1288B8};
    vecs[1] = '{16'h0050, 4'b0000, 1'b1, 32'hFFFFA481};
    vecs[2] = '{16'h0050, 4'b0000, 1'b0, 32'h8181A481};
    vecs[3] = '{16'h0000, 4'b0010, 1'b1, 32'hFFFFFF81};
    vecs[4] = '{16'h0F0A, 4'b0001, 1'b1, 32'hFFB88108};
    vecs[5] = '{16'h3C9E, 4'b1000, 1'b1, 32'h06B184B0};

    // reset held, then release and watch two full scans
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2 * FRAME) step();

    // vector table: load, wait for transfer, read back one frame
    for (int v = 0; v < 6; v++) begin
      lz_en = vecs[v].lz;
      do_load(vecs[v].data, vecs[v].dp);
      chk($sformatf("vec%0d_busy", v), busy, m_busy);
      wait_frame();
      capture();
      for (int j = 0; j < 4; j++)
        chk($sformatf("vec%0d_dig%0d", v, j), got[j], vecs[v].segs[8*j +: 8]);
    end

    // load coincident with the frame boundary
    lz_en = 1'b0;
    for (int i = 0; i < 2 * FRAME && k != FRAME - 1; i++) step();
    do_load(16'h7777, 4'b0000);
    chk("coinc_busy", busy, 0);
    chk("coinc_frame_done", frame_done, 1);
    capture();
    for (int j = 0; j < 4; j++) chk($sformatf("coinc_dig%0d", j), got[j], 8'h8F);

    // back-to-back loads: only the last survives
    wait_frame();
    do_load(16'h1111, 4'b0000);
    do_load(16'h2222, 4'b0000);
    chk("overwrite_busy", busy, 1);
    wait_frame();
    capture();
    for (int j = 0; j < 4; j++) chk($sformatf("overwrite_dig%0d", j), got[j], 8'h92);

    // reset while a load is pending
    wait_frame();
    do_load(16'h1111, 4'b0000);
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_async_seg", seg, 8'hFF);
    chk("rst_async_dig", dig_sel, 4'hF);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_busy_after", busy, 0);
    capture();
    for (int j = 0; j < 4; j++) chk($sformatf("rst_dig%0d", j), got[j], 8'h81);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 7) == 0);
      data_in = 16'($urandom);
      if ($urandom_range(0, 1) == 0) data_in = data_in & 16'h00FF;
      dp_in = 4'($urandom);
      if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
      step();
    end
    load = 1'b0;
    repeat (FRAME) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
